// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deser
// Purpose  : Serial-in / parallel-out deserializer. Collects a registered
//            single-bit stream, MSB first, into WIDTH-bit words and presents
//            each completed word in a holding register with a valid/ready
//            handshake. A sticky overrun flag records words dropped because
//            the holding register was full. An even-parity check per frame
//            is available when the SIPO_PARITY_EN macro is defined.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous reset, active-high
//            s_in       - serial data bit
//            s_valid    - s_in is sampled on this edge when high
//            clear      - synchronous abort of partial word and overrun flag
//            p_data     - completed word (first received bit in the MSB)
//            p_valid    - p_data holds an unconsumed word
//            p_ready    - consumer accepts p_data when p_valid is also high
//            busy       - partial word in progress
//            overrun    - sticky, a completed word was dropped
//            parity_err - parity status of p_data (SIPO_PARITY_EN only)
// Config   : SIPO_PARITY_EN - adds the PAR state and the parity_err port;
//            each frame becomes WIDTH data bits plus one even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overrun
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    // Only WIDTH-1 bits of history are needed: the last bit of a word comes
    // straight from s_in on the completing edge.
    logic [WIDTH-2:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] w_sh_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_word;
    logic             w_offer;
    logic [WIDTH-1:0] w_offer_word;

`ifdef SIPO_PARITY_EN
    localparam logic [0:0] S_SHIFT = 1'b0;
    localparam logic [0:0] S_PAR   = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_word_nxt;
    logic             w_offer_perr;
`endif

    assign w_word = {r_sh, s_in};

    // ------------------------------------------------------------------
    // Next-state / offer logic
    // ------------------------------------------------------------------
    always_comb begin
        w_sh_nxt     = r_sh;
        w_cnt_nxt    = r_cnt;
        w_offer      = 1'b0;
        w_offer_word = w_word;
`ifdef SIPO_PARITY_EN
        w_state_nxt  = r_state;
        w_word_nxt   = r_word;
        w_offer_perr = 1'b0;
`endif
        if (clear) begin
            // clear wins over s_valid: nothing is sampled on this edge
            w_sh_nxt    = '0;
            w_cnt_nxt   = '0;
`ifdef SIPO_PARITY_EN
            w_state_nxt = S_SHIFT;
`endif
        end else if (s_valid) begin
`ifdef SIPO_PARITY_EN
            if (r_state == S_PAR) begin
                // s_in is the even-parity bit for the latched word
                w_offer      = 1'b1;
                w_offer_word = r_word;
                w_offer_perr = (^r_word) ^ s_in;
                w_state_nxt  = S_SHIFT;
            end else begin
`endif
                w_sh_nxt = w_word[WIDTH-2:0];
                if (r_cnt == c_last) begin
                    w_cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
                    w_word_nxt  = w_word;
                    w_state_nxt = S_PAR;
`else
                    w_offer     = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
`ifdef SIPO_PARITY_EN
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Shift register, bit count and state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh    <= '0;
            r_cnt   <= '0;
`ifdef SIPO_PARITY_EN
            r_state <= S_SHIFT;
            r_word  <= '0;
`endif
        end else begin
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef SIPO_PARITY_EN
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Holding register with valid/ready handshake and overrun flag.
    // An offered word is accepted if the register is empty or is being
    // drained on this same edge, which sustains one word per frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_data     <= '0;
            p_valid    <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (clear) begin
                overrun <= 1'b0;
            end
            if (w_offer) begin
                if (!p_valid || p_ready) begin
                    p_data     <= w_offer_word;
                    p_valid    <= 1'b1;
`ifdef SIPO_PARITY_EN
                    parity_err <= w_offer_perr;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    assign busy = (r_cnt != '0) || (r_state == S_PAR);
`else
    assign busy = (r_cnt != '0);
`endif

endmodule
`default_nettype wire
